// File: rtl/frame_swap_controller_pkg.sv
// Shared types and defaults for the double-buffer frame swap controller.
package frame_swap_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAWING,
    READY,
    SWAP,
    PAUSED
  } swap_state_t;

  localparam int DEFAULT_CNT_WIDTH     = 16;
  localparam int DEFAULT_MIN_VBLANKS   = 2;
  localparam int DEFAULT_STALL_VBLANKS = 8;

  // Bits needed to hold 0..max_value (never less than one bit).
  function automatic int count_bits(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/frame_swap_controller_if.sv
// Handshake bundle between VGA timing, the drawing manager and the swap controller.
interface frame_swap_controller_if
  import frame_swap_controller_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) ();

  logic                 enable;
  logic                 vblank_start;
  logic                 frame_done;
  logic                 draw_start;
  logic                 draw_ack;
  logic                 write_buffer_select;
  logic                 read_buffer_select;
  logic [CNT_WIDTH-1:0] swap_count;
  logic [CNT_WIDTH-1:0] missed_count;
  logic                 stall;

  modport master (
    output enable, vblank_start, frame_done,
    input  draw_start, draw_ack, write_buffer_select, read_buffer_select,
    input  swap_count, missed_count, stall
  );

  modport slave (
    input  enable, vblank_start, frame_done,
    output draw_start, draw_ack, write_buffer_select, read_buffer_select,
    output swap_count, missed_count, stall
  );

endinterface

// File: rtl/frame_swap_controller_sat_counter.sv
// Up-counter that holds at MAX; clear wins over increment.
module sat_counter #(
  parameter int             WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value_reg <= '0;
    end else if (inc && (value_reg != MAX)) begin
      value_reg <= value_reg + 1'b1;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/frame_swap_controller.sv
// Double-buffer sequencer: runs the drawing manager, flips front/back buffers at vblank.
module frame_swap_controller
  import frame_swap_controller_pkg::*;
#(
  parameter int MIN_VBLANKS   = DEFAULT_MIN_VBLANKS,
  parameter int STALL_VBLANKS = DEFAULT_STALL_VBLANKS,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  frame_swap_controller_if.slave bus
);

  localparam int VB_WIDTH    = count_bits(MIN_VBLANKS);
  localparam int DWELL_WIDTH = count_bits(STALL_VBLANKS);

  swap_state_t state_reg;
  swap_state_t state_next;

  logic read_sel_reg;
  logic write_sel_reg;
  logic draw_start_reg;
  logic draw_ack_reg;
  logic stall_reg;
  logic draw_start_next;
  logic draw_ack_next;
  logic swap_go;
  logic eligible;
  logic stall_hit;

  logic [VB_WIDTH-1:0]    vb_cnt;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [CNT_WIDTH-1:0]   stat_value [2];
  logic [1:0]             stat_inc;

  assign eligible  = bus.vblank_start && ((int'(vb_cnt) + 1) >= MIN_VBLANKS);
  assign stall_hit = (state_reg == DRAWING) && bus.vblank_start &&
                     ((int'(dwell) + 1) >= STALL_VBLANKS);

  // vb_cnt keeps running outside IDLE so the rate cap spans swap to swap.
  sat_counter #(
    .WIDTH (VB_WIDTH),
    .MAX   (VB_WIDTH'(MIN_VBLANKS))
  ) u_vb_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (swap_go),
    .inc   (bus.vblank_start && (state_reg != IDLE)),
    .value (vb_cnt)
  );

  sat_counter #(
    .WIDTH (DWELL_WIDTH),
    .MAX   (DWELL_WIDTH'(STALL_VBLANKS))
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (swap_go),
    .inc   (bus.vblank_start && (state_reg == DRAWING)),
    .value (dwell)
  );

  assign stat_inc[0] = swap_go;
  assign stat_inc[1] = (state_reg == DRAWING) && eligible;

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    sat_counter #(
      .WIDTH (CNT_WIDTH)
    ) u_stat (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (stat_inc[gi]),
      .value (stat_value[gi])
    );
  end

  always_comb begin
    state_next      = state_reg;
    draw_start_next = 1'b0;
    draw_ack_next   = 1'b0;
    swap_go         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.enable) begin
          state_next      = DRAWING;
          draw_start_next = 1'b1;
        end
      end
      DRAWING: begin
        // While our ack is on the wire the manager still shows the old frame_done.
        if (bus.frame_done && !draw_ack_reg) begin
          state_next = READY;
        end
      end
      READY: begin
        if (eligible) begin
          swap_go       = 1'b1;
          state_next    = SWAP;
          draw_ack_next = bus.enable;
        end
      end
      SWAP: begin
        state_next = draw_ack_reg ? DRAWING : PAUSED;
      end
      PAUSED: begin
        if (bus.enable) begin
          state_next    = DRAWING;
          draw_ack_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      read_sel_reg   <= 1'b0;
      write_sel_reg  <= 1'b1;
      draw_start_reg <= 1'b0;
      draw_ack_reg   <= 1'b0;
      stall_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      draw_start_reg <= draw_start_next;
      draw_ack_reg   <= draw_ack_next;
      if (swap_go) begin
        read_sel_reg  <= ~read_sel_reg;
        write_sel_reg <= read_sel_reg;
      end
      if (stall_hit) begin
        stall_reg <= 1'b1;
      end
    end
  end

  assign bus.draw_start          = draw_start_reg;
  assign bus.draw_ack            = draw_ack_reg;
  assign bus.read_buffer_select  = read_sel_reg;
  assign bus.write_buffer_select = write_sel_reg;
  assign bus.stall               = stall_reg;
  assign bus.swap_count          = stat_value[0];
  assign bus.missed_count        = stat_value[1];

endmodule
